pipe_hazard_ctrl: RTL

- Central pipeline sequencer for the 5-stage MIPS core.
- Drives write-enable and bubble controls for the PC, IF/ID, ID/EX and EX/MEM stage registers.
- Resolves load-use hazards and taken branches that resolve in MEM.
- Stalls the whole pipe during multi-cycle data-memory accesses, using a ready handshake with a timeout fault.

---
 rtl/pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the 5-stage MIPS core.
// Generates the stage-register write enables and bubble/flush controls for
// PC, IF/ID, ID/EX and EX/MEM. It handles load-use stalls, MEM-resolved taken
// branches, and whole-pipe freezes during multi-cycle data-memory accesses.
// A memory access with no dmem_ready for MEM_TIMEOUT+1 consecutive cycles
// raises a sticky fault.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_rs, id_rt               source fields of the instruction in ID
//   idex_memread, idex_rt      load flag and destination held in ID/EX
//   exmem_branch, exmem_zero   branch resolution in MEM
//   exmem_memaccess            EX/MEM holds a load or store
//   dmem_ready                 data memory completes the access this cycle
//   pc_write .. exmem_bubble   stage-register controls (combinational)
//   pc_src                     select branch target (combinational)
//   dmem_req                   data memory request (combinational)
//   mem_fault                  sticky timeout flag (registered)
//   stall_count                saturating count of cycles with pc_write=0
//
// Build option: define PIPE_STALL_CNT_EN to build the stall counter;
// otherwise stall_count is tied to zero.

module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memaccess,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_bubble,
    output logic             pc_src,
    output logic             dmem_req,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_fault_q, mem_fault_d;
    logic                load_use;
    logic                br_taken;
    logic                decode;

    // Hazard detection on the current stage contents.
    always_comb begin
        load_use = idex_memread && (idex_rt != 5'd0) &&
                   ((idex_rt == id_rs) || (idex_rt == id_rt));
        br_taken = exmem_branch && exmem_zero;
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_fault_d  = mem_fault_q;
        decode       = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_bubble = 1'b0;
        pc_src       = 1'b0;
        dmem_req     = exmem_memaccess;

        case (state_q)
            ST_RUN: begin
                if (exmem_memaccess && !dmem_ready) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    dmem_req    = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    wait_cnt_d  = WAIT_W'(1);
                end else begin
                    decode = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    // Access completes: this cycle behaves as a normal RUN cycle.
                    decode     = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d     = ST_FAULT;
                        mem_fault_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                dmem_req    = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Branch flushes the ID instruction, so it masks a load-use stall.
        if (decode) begin
            if (br_taken) begin
                pc_src       = 1'b1;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        // During reset every stage loads a NOP and any request is dropped.
        if (!rst_n) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            idex_write   = 1'b1;
            exmem_write  = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            pc_src       = 1'b0;
            dmem_req     = 1'b0;
        end
    end

    // State, wait counter and fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign mem_fault = mem_fault_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Saturating count of PC-stalled cycles; the frozen FAULT state is excluded.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (state_q != ST_FAULT) && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule
